countdown_timer: RTL and testbench
==================================

# countdown_timer

Parametrised countdown timer for the game-round clock and other timed events in the design. A single clock domain drives an internal prescaler that produces a one-cycle tick enable at `TICK_HZ`; the counter itself runs on `clk` and never uses a derived clock. The block supports a runtime load value, pause/resume, one-shot or auto-reload mode, and a one-cycle expiry pulse. It feeds the display path through `count`, and game control through `expired` and `running`.

## Interface
- `CLK_HZ`, 100_000_000, input clock frequency.
- `TICK_HZ`, 1, decrement rate. `DIV = CLK_HZ/TICK_HZ` must be an integer and at least 2 (elaboration error otherwise).
- `COUNT_W`, 5, counter width.
- `clk`  in  1  system clock; all state is updated on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  level sampled each cycle; high loads `load_val`, latches `mode`, and (re)starts the timer.
- `pause`  in  1  level; while high, a running timer freezes.
- `load_val`  in  COUNT_W  start value; also becomes the reload value.
- `mode`  in  1  0 = one-shot, 1 = auto-reload. Sampled only on `start`.
- `count`  out  COUNT_W  current count.
- `running`  out  1  high in RUN or PAUSED.
- `expired`  out  1  one-cycle pulse each time the count expires.
- `tick`  out  1  one-cycle prescaler pulse; asserts only in RUN.

## Operation
- States:
  - IDLE: after reset.
  - RUN: counting.
  - PAUSED: frozen.
  - DONE: one-shot finished, `count` holds 0.
- Reset (async): state IDLE, `count`=0, `running`=0, `expired`=0, `tick`=0, prescaler=0, reload register=0, mode register=0.
- Start:
  - `start`=1 in any state: `count`←`load_val`, reload←`load_val`, mode reg←`mode`, prescaler←0, state←RUN.
  - `start` has priority over `pause` and over a coincident tick.
  - `load_val`=0 on start: `count`=0, `expired` pulses next cycle, state←DONE. This applies in either mode; there is no auto-reload from 0.
- RUN:
  - Prescaler counts 0..DIV-1; `tick`=1 when prescaler==DIV-1.
  - On tick with `count`>1: `count`←`count`-1.
  - On tick with `count`==1:
    - One-shot: `count`←0, `expired`←1, state←DONE.
    - Reload: `count`←reload value, `expired`←1, stay in RUN, prescaler wraps to 0.
- PAUSED:
  - Entered from RUN when `pause`=1. Returns to RUN when `pause`=0.
  - Prescaler and `count` hold, so the phase is preserved.
  - A pause that coincides with a tick cycle suppresses that tick; it is re-issued after resume.
  - `pause` in IDLE or DONE is ignored.
- DONE and IDLE: prescaler held at 0. Only `start` leaves these states.
- Arithmetic: unsigned, no underflow. A decrement from 0 is unreachable.

## Timing
- `start` sampled high at edge N:
  - `count`=`load_val` and `running`=1 from cycle N+1.
  - The first decrement is visible at N+1+DIV, so each count value lasts exactly DIV cycles.
- One-shot from L: `count` reaches 0, and `expired` is high for that same single cycle, at N+1+L·DIV.
- Reload from L: `expired` pulses every L·DIV cycles. The displayed sequence is L..1 repeating (0 is never shown).
- Pause of P cycles during RUN delays all later events by exactly P cycles.
- `expired`, `count`, `running`: registered outputs. `tick`: decoded from registered prescaler and state (no input-to-output combinational path).

## Structure
- `timer_pkg`: state enum (`ST_IDLE`, `ST_RUN`, `ST_PAUSED`, `ST_DONE`), constants `MODE_ONESHOT`=0 and `MODE_RELOAD`=1.
- Sub-module `tick_prescaler`:
  - Parameter `DIV`; inputs `clk`, `rst`, `clr`, `en`; output `tick`.
  - Counter width `$clog2(DIV)`.
  - Replaces any divided-clock scheme.
- Top: state machine, count and reload registers, expiry logic.

## Test plan
All scenarios use CLK_HZ=4, TICK_HZ=1 (DIV=4) and COUNT_W=5.
- Reset asserted mid-cycle while running from 20 -> all outputs 0 immediately, with no clock edge; state IDLE.
- One-shot start, `load_val`=3 -> `count` 3,2,1,0 with each value held 4 cycles; single `expired` pulse 13 cycles after the start edge; `running`=0 afterwards; later ticks do nothing.
- Reload start, `load_val`=2 -> `count` 2,1,2,1…; `expired` pulses every 8 cycles; `running` stays 1.
- `pause` high for 10 cycles, 2 cycles into a count period -> `count` and `tick` frozen; the next decrement arrives 12 cycles later (2 before the pause + 10 paused), i.e. 10 cycles later than unpaused.
- `start` with `load_val`=30 while running at count 7, on a tick cycle -> `count`=30 next cycle; no decrement; prescaler phase restarted.
- `start` with `load_val`=0 -> `count`=0 and `expired` pulse next cycle; state DONE; `count` stays 0 with no further pulses.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared state encoding and mode constants for the countdown timer.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

endpackage

// File: rtl/countdown_timer_tick_prescaler.sv
// Clock-enable prescaler: wraps every DIV enabled cycles and flags the last phase.
module tick_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
    end
  end

  assign tick = (r_cnt == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer with runtime load, pause/resume, one-shot or auto-reload and expiry pulse.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned TICK_HZ = 1,
  parameter int unsigned COUNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               pause,
  input  logic [COUNT_W-1:0] load_val,
  input  logic               mode,
  output logic [COUNT_W-1:0] count,
  output logic               running,
  output logic               expired,
  output logic               tick
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2) begin : g_bad_div
    $error("countdown_timer: CLK_HZ/TICK_HZ must be an integer >= 2");
  end

  state_t             r_state;
  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_reload;
  logic               r_mode;
  logic               r_expired;

  logic w_active;
  logic w_pre_tick;
  logic w_idle_or_done;

  // The resume cycle already counts so a pause of P cycles costs exactly P cycles.
  assign w_active       = ((r_state == ST_RUN) || (r_state == ST_PAUSED)) && !pause;
  assign w_idle_or_done = (r_state == ST_IDLE) || (r_state == ST_DONE);

  tick_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (start || w_idle_or_done),
    .en   (w_active),
    .tick (w_pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_reload  <= '0;
      r_mode    <= MODE_ONESHOT;
      r_expired <= 1'b0;
    end else begin
      r_expired <= 1'b0;
      if (start) begin
        r_count  <= load_val;
        r_reload <= load_val;
        r_mode   <= mode;
        if (load_val == '0) begin
          r_state   <= ST_DONE;
          r_expired <= 1'b1;
        end else begin
          r_state <= ST_RUN;
        end
      end else begin
        case (r_state)
          ST_RUN, ST_PAUSED: begin
            if (pause) begin
              r_state <= ST_PAUSED;
            end else begin
              r_state <= ST_RUN;
              if (w_pre_tick) begin
                if (r_count == COUNT_W'(1)) begin
                  r_expired <= 1'b1;
                  if (r_mode == MODE_RELOAD) begin
                    r_count <= r_reload;
                  end else begin
                    r_count <= '0;
                    r_state <= ST_DONE;
                  end
                end else if (r_count != '0) begin
                  r_count <= r_count - COUNT_W'(1);
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign count   = r_count;
  assign running = (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign expired = r_expired;
  assign tick    = (r_state == ST_RUN) && w_pre_tick;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench: stimulus queues expected output events, a negedge monitor pops and compares them.
module tb_countdown_timer;
  import timer_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic       mode = 1'b0;
  logic [4:0] load_val = '0;
  logic [4:0] count;
  logic       running;
  logic       expired;
  logic       tick;

  always #5 clk = ~clk;

  countdown_timer #(
    .CLK_HZ  (4),
    .TICK_HZ (1),
    .COUNT_W (5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .load_val (load_val),
    .mode     (mode),
    .count    (count),
    .running  (running),
    .expired  (expired),
    .tick     (tick)
  );

  typedef struct {
    int unsigned cyc;
    logic [4:0]  count;
    logic        exp;
    logic        run;
  } ev_t;

  ev_t         q[$];
  int unsigned cyc = 0;
  int unsigned tick_seen = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (tick === 1'b1) tick_seen <= tick_seen + 1;

  task automatic push(input int unsigned c, input logic [4:0] cnt, input logic e, input logic r);
    ev_t ev;
    ev.cyc = c; ev.count = cnt; ev.exp = e; ev.run = r;
    q.push_back(ev);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: an event is any count change, running change or expiry pulse.
  initial begin
    logic [4:0] pc;
    logic       pr;
    ev_t        e;
    pc = '0;
    pr = 1'b0;
    forever begin
      @(negedge clk);
      if (count !== pc || expired === 1'b1 || running !== pr) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: cyc=%0d count=%0d expired=%b running=%b, required no event",
                   cyc, count, expired, running);
        end else begin
          e = q.pop_front();
          if (e.cyc != cyc || e.count !== count || e.exp !== expired || e.run !== running) begin
            errors++;
            $display("FAIL event: got cyc=%0d count=%0d expired=%b running=%b, required cyc=%0d count=%0d expired=%b running=%b",
                     cyc, count, expired, running, e.cyc, e.count, e.exp, e.run);
          end
        end
      end
      pc = count;
      pr = running;
    end
  end

  initial begin
    int unsigned s, s2, s3, t, t0;

    @(posedge clk);
    #2;
    chk("reset_count", 32'(count), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_expired", 32'(expired), 0);
    chk("reset_tick", 32'(tick), 0);
    step(1);
    rst = 1'b0;
    step(1);

    // One-shot from 3
    s = cyc + 1;
    push(s, 5'd3, 1'b0, 1'b1);
    push(s + 4, 5'd2, 1'b0, 1'b1);
    push(s + 8, 5'd1, 1'b0, 1'b1);
    push(s + 12, 5'd0, 1'b1, 1'b0);
    start = 1'b1; load_val = 5'd3; mode = MODE_ONESHOT;
    step(1);
    start = 1'b0;
    step(12);
    t0 = tick_seen;
    step(19);
    chk("done_no_tick", tick_seen - t0, 0);

    // Auto-reload from 2
    s = cyc + 1;
    push(s, 5'd2, 1'b0, 1'b1);
    push(s + 4, 5'd1, 1'b0, 1'b1);
    push(s + 8, 5'd2, 1'b1, 1'b1);
    push(s + 12, 5'd1, 1'b0, 1'b1);
    push(s + 16, 5'd2, 1'b1, 1'b1);
    push(s + 20, 5'd1, 1'b0, 1'b1);
    push(s + 24, 5'd2, 1'b1, 1'b1);
    start = 1'b1; load_val = 5'd2; mode = MODE_RELOAD;
    step(1);
    start = 1'b0;
    step(25);

    // Restart with 30 on a tick cycle while at 7
    s2 = cyc + 1;
    push(s2, 5'd8, 1'b0, 1'b1);
    push(s2 + 4, 5'd7, 1'b0, 1'b1);
    start = 1'b1; load_val = 5'd8; mode = MODE_ONESHOT;
    step(1);
    start = 1'b0;
    step(7);
    chk("tick_before_restart", 32'(tick), 1);
    chk("count_before_restart", 32'(count), 7);
    s3 = cyc + 1;
    push(s3, 5'd30, 1'b0, 1'b1);
    push(s3 + 4, 5'd29, 1'b0, 1'b1);
    start = 1'b1; load_val = 5'd30;
    step(1);
    start = 1'b0;

    // Pause for 10 cycles, 2 cycles into the period starting at t
    t = s3 + 4;
    step(5);
    pause = 1'b1;
    push(t + 14, 5'd28, 1'b0, 1'b1);
    step(1);
    step(5);
    chk("paused_tick", 32'(tick), 0);
    chk("paused_count", 32'(count), 29);
    step(4);
    pause = 1'b0;
    step(2);
    chk("resumed_tick", 32'(tick), 1);
    step(1);
    step(2);

    // Start with zero load
    s = cyc + 1;
    push(s, 5'd0, 1'b1, 1'b0);
    start = 1'b1; load_val = 5'd0; mode = MODE_RELOAD;
    step(1);
    start = 1'b0;
    t0 = tick_seen;
    step(20);
    chk("zero_load_no_tick", tick_seen - t0, 0);

    // Asynchronous reset mid-cycle while running from 20
    s = cyc + 1;
    push(s, 5'd20, 1'b0, 1'b1);
    push(s + 4, 5'd19, 1'b0, 1'b1);
    start = 1'b1; load_val = 5'd20; mode = MODE_ONESHOT;
    step(1);
    start = 1'b0;
    step(5);
    #2;
    push(cyc, 5'd0, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_running", 32'(running), 0);
    chk("async_rst_expired", 32'(expired), 0);
    chk("async_rst_tick", 32'(tick), 0);
    step(2);
    rst = 1'b0;
    t0 = tick_seen;
    step(10);
    chk("idle_no_tick", tick_seen - t0, 0);
    chk("idle_count", 32'(count), 0);

    step(3);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
